// File: rtl/pcie_csr_pkg.sv
// CSR map constants and helpers shared by the PCIe BAR0 CSR responder.
package pcie_csr_pkg;

  localparam int unsigned CSR_AW         = 3;
  localparam logic [31:0] CSR_ID_DEFAULT = 32'hC0DE_0001;
  localparam int unsigned BTN_W          = 4;
  localparam int unsigned LED_W          = 4;

  // Word offsets of the CSRs inside BAR0
  typedef enum logic [2:0] {
    CSR_ID       = 3'd0,
    CSR_SCRATCH  = 3'd1,
    CSR_LED      = 3'd2,
    CSR_BTN      = 3'd3,
    CSR_EDGE     = 3'd4,
    CSR_IRQ_MASK = 3'd5,
    CSR_CYC_LO   = 3'd6,
    CSR_CYC_HI   = 3'd7
  } csr_addr_e;

  // Byte-lane merge of new write data into an existing 32-bit register
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/csr_button_edge.sv
// Button front end: 2-flop synchronizer, press-edge detect and a
// write-one-to-clear capture register. A press arriving in the same cycle
// as a clear of that bit keeps the bit set.
module csr_button_edge
  import pcie_csr_pkg::*;
#(
  parameter int unsigned W = BTN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] button_in,
  input  logic [W-1:0] clr,
  output logic [W-1:0] btn_level,
  output logic [W-1:0] edge_bits
);

  logic [W-1:0] sync1_r;
  logic [W-1:0] sync2_r;
  logic [W-1:0] prev_r;
  logic [W-1:0] edge_r;
  logic [W-1:0] press_s;

  // Buttons idle high, so a released button never looks like a press
  assign press_s   = prev_r & ~sync2_r;
  assign btn_level = ~sync2_r;
  assign edge_bits = edge_r;

  // Synchronize raw buttons and capture press edges with W1C clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '1;
      sync2_r <= '1;
      prev_r  <= '1;
      edge_r  <= '0;
    end else begin
      sync1_r <= button_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      edge_r  <= (edge_r & ~clr) | press_s;
    end
  end

endmodule

// File: rtl/pcie_bar_csr_responder.sv
// Avalon-MM pipelined slave serving the PCIe BAR0 CSR map (ID, scratch,
// LEDs, buttons, edge capture, 64-bit cycle counter).
// Optional feature macro: CSR_IRQ_EN adds IRQ_MASK storage and the irq port.
module pcie_bar_csr_responder
  import pcie_csr_pkg::*;
#(
  parameter int unsigned ADDR_W       = CSR_AW,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] ID_VALUE     = CSR_ID_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic [LED_W-1:0]  led_out,
  input  logic [BTN_W-1:0]  button_in
`ifdef CSR_IRQ_EN
 ,output logic              irq
`endif
);

  logic                    wait_r;
  logic [31:0]             scratch_r;
  logic [LED_W-1:0]        led_r;
  logic [63:0]             cyc_cnt_r;
  logic [31:0]             cyc_shadow_r;
  logic [READ_LATENCY-1:0] pipe_vld_r;
  logic [31:0]             pipe_dat_r [READ_LATENCY];
  logic                    rd_acc_s;
  logic                    wr_acc_s;
  logic [31:0]             rd_data_s;
  logic [BTN_W-1:0]        edge_clr_s;
  logic [BTN_W-1:0]        btn_level_s;
  logic [BTN_W-1:0]        edge_bits_s;
`ifdef CSR_IRQ_EN
  logic [BTN_W-1:0]        mask_r;
  logic                    irq_r;
`endif

  assign rd_acc_s          = avs_read & ~wait_r;
  assign wr_acc_s          = avs_write & ~wait_r;
  assign avs_waitrequest   = wait_r;
  assign avs_readdata      = pipe_dat_r[READ_LATENCY-1];
  assign avs_readdatavalid = pipe_vld_r[READ_LATENCY-1];
  assign led_out           = led_r;

  csr_button_edge #(.W(BTN_W)) u_button_edge (
    .clk       (clk),
    .rst       (rst),
    .button_in (button_in),
    .clr       (edge_clr_s),
    .btn_level (btn_level_s),
    .edge_bits (edge_bits_s)
  );

  // W1C clear strobe for the edge register, only on an accepted low-byte write
  always_comb begin
    edge_clr_s = '0;
    if (wr_acc_s && (avs_address == ADDR_W'(CSR_EDGE)) && avs_byteenable[0]) begin
      edge_clr_s = avs_writedata[BTN_W-1:0];
    end else begin
      edge_clr_s = '0;
    end
  end

  // Read mux, sampled at the accept edge
  always_comb begin
    rd_data_s = 32'd0;
    case (avs_address)
      ADDR_W'(CSR_ID):       rd_data_s = ID_VALUE;
      ADDR_W'(CSR_SCRATCH):  rd_data_s = scratch_r;
      ADDR_W'(CSR_LED):      rd_data_s = {28'd0, led_r};
      ADDR_W'(CSR_BTN):      rd_data_s = {28'd0, btn_level_s};
      ADDR_W'(CSR_EDGE):     rd_data_s = {28'd0, edge_bits_s};
`ifdef CSR_IRQ_EN
      ADDR_W'(CSR_IRQ_MASK): rd_data_s = {28'd0, mask_r};
`else
      ADDR_W'(CSR_IRQ_MASK): rd_data_s = 32'd0;
`endif
      ADDR_W'(CSR_CYC_LO):   rd_data_s = cyc_cnt_r[31:0];
      ADDR_W'(CSR_CYC_HI):   rd_data_s = cyc_shadow_r;
      default:               rd_data_s = 32'd0;
    endcase
  end

  // Register file, cycle counter with hi-word snapshot, and start-up stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_r       <= 1'b1;
      scratch_r    <= 32'd0;
      led_r        <= '0;
      cyc_cnt_r    <= 64'd0;
      cyc_shadow_r <= 32'd0;
`ifdef CSR_IRQ_EN
      mask_r       <= '0;
`endif
    end else begin
      wait_r    <= 1'b0;
      cyc_cnt_r <= cyc_cnt_r + 64'd1;
      if (rd_acc_s && (avs_address == ADDR_W'(CSR_CYC_LO))) begin
        cyc_shadow_r <= cyc_cnt_r[63:32];
      end
      if (wr_acc_s) begin
        case (avs_address)
          ADDR_W'(CSR_SCRATCH): scratch_r <= be_merge(scratch_r, avs_writedata, avs_byteenable);
          ADDR_W'(CSR_LED): begin
            if (avs_byteenable[0]) led_r <= avs_writedata[LED_W-1:0];
          end
`ifdef CSR_IRQ_EN
          ADDR_W'(CSR_IRQ_MASK): begin
            if (avs_byteenable[0]) mask_r <= avs_writedata[BTN_W-1:0];
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  // Read-return pipeline: fixed-latency shift of {valid, data}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat_r[i] <= 32'd0;
    end else begin
      pipe_vld_r[0] <= rd_acc_s;
      pipe_dat_r[0] <= rd_acc_s ? rd_data_s : 32'd0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_dat_r[i] <= pipe_dat_r[i-1];
      end
    end
  end

`ifdef CSR_IRQ_EN
  // Level interrupt from masked edge bits, one cycle behind the sources
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(edge_bits_s & mask_r);
    end
  end

  assign irq = irq_r;
`endif

endmodule
